mbist_march_ctrl: RTL and testbench

- March C- BIST sequencer that sits directly upstream of fault_mem.
- Drives fault_mem's write_read/address/wdata interface, one memory operation per clock.
- Compares every read against the expected background word and reports pass/fail, first-fail address/element and a fail count to the top-level BIST wrapper.
- Matches fault_mem timing exactly: write data is consumed one cycle late; read data is returned two cycles after the read is issued.

---
 rtl/mbist_march_ctrl_pkg.sv | 36 +++
 rtl/mbist_march_ctrl_cmp_pipe.sv | 102 ++++++++++
 rtl/mbist_march_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_march_ctrl_pkg.sv
// Shared encodings for the March C- BIST controller: FSM states, March
// element indices and the per-element direction/op/background tables.
package mbist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      E0 = 3'd0,
      E1 = 3'd1,
      E2 = 3'd2,
      E3 = 3'd3,
      E4 = 3'd4,
      E5 = 3'd5
   } elem_t;

   // Bit i of each table describes element Ei.
   // Direction: 1 = ascending (0 -> CAPACITY), 0 = descending.
   localparam logic [7:0] ELEM_UP      = 8'b0010_0111;
   // 1 = element is a read/write pair per address, 0 = single operation.
   localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
   // Background expected by the element's read (0 = D0, 1 = D1).
   localparam logic [7:0] ELEM_RD_BG   = 8'b0001_0100;
   // Background written by the element's write (0 = D0, 1 = D1).
   localparam logic [7:0] ELEM_WR_BG   = 8'b0000_1010;

   // E0 is write-only, E5 is read-only; paired elements read first, then write.
   function automatic logic elem_is_write(elem_t e, logic ph);
      return (e == E0) || (ELEM_TWO_OPS[e] && ph);
   endfunction

endpackage

// File: rtl/mbist_march_ctrl_cmp_pipe.sv
// Two-stage delay of the expected word/address/element for each issued read,
// the read-data comparator and the sticky fail / first-fail / count capture.
module mbist_cmp_pipe
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  iss_valid,
   input  logic [DATA_WIDTH-1:0] iss_exp,
   input  logic [ADDR_WIDTH-1:0] iss_addr,
   input  logic [2:0]            iss_elem,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic [CNT_WIDTH-1:0]  fail_cnt
);

   logic                  s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
   logic [DATA_WIDTH-1:0] s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
   logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
   logic [2:0]            s1_elem_q, s1_elem_d, s2_elem_q, s2_elem_d;
   logic                  fail_q, fail_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]            fail_elem_q, fail_elem_d;
   logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
   logic                  mismatch;

   // Delay line and fail bookkeeping; a new run's clear wins over any compare.
   always_comb begin
      s1_vld_d    = iss_valid;
      s1_exp_d    = iss_exp;
      s1_addr_d   = iss_addr;
      s1_elem_d   = iss_elem;
      s2_vld_d    = s1_vld_q;
      s2_exp_d    = s1_exp_q;
      s2_addr_d   = s1_addr_q;
      s2_elem_d   = s1_elem_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      fail_cnt_d  = fail_cnt_q;
      mismatch    = s2_vld_q && (rdata != s2_exp_q);
      if (clr) begin
         fail_d      = 1'b0;
         fail_addr_d = '0;
         fail_elem_d = '0;
         fail_cnt_d  = '0;
      end else if (mismatch) begin
         if (fail_cnt_q != '1) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
         end
         if (!fail_q) begin
            fail_addr_d = s2_addr_q;
            fail_elem_d = s2_elem_q;
         end
         fail_d = 1'b1;
      end
   end

   // Pipeline and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         s1_exp_q    <= '0;
         s1_addr_q   <= '0;
         s1_elem_q   <= '0;
         s2_vld_q    <= 1'b0;
         s2_exp_q    <= '0;
         s2_addr_q   <= '0;
         s2_elem_q   <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         fail_cnt_q  <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_exp_q    <= s1_exp_d;
         s1_addr_q   <= s1_addr_d;
         s1_elem_q   <= s1_elem_d;
         s2_vld_q    <= s2_vld_d;
         s2_exp_q    <= s2_exp_d;
         s2_addr_q   <= s2_addr_d;
         s2_elem_q   <= s2_elem_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         fail_cnt_q  <= fail_cnt_d;
      end
   end

   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;
   assign fail_cnt  = fail_cnt_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer driving fault_mem: FSM plus element/address/op
// sequencer. Write data is presented one cycle ahead of its operation; read
// checking is delegated to mbist_cmp_pipe.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CAPACITY   = 15,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  write_read,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic [CNT_WIDTH-1:0]  fail_cnt
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);

   // Position of one March operation: element, address, and which half of a
   // read/write pair (ph=0 read, ph=1 write).
   typedef struct packed {
      elem_t                 elem;
      logic [ADDR_WIDTH-1:0] addr;
      logic                  ph;
   } pos_t;

   localparam pos_t POS_FIRST = '{elem: E0, addr: '0, ph: 1'b0};

   function automatic pos_t next_pos(pos_t p);
      pos_t n;
      n = p;
      if (ELEM_TWO_OPS[p.elem] && !p.ph) begin
         n.ph = 1'b1;
      end else begin
         n.ph = 1'b0;
         if ((ELEM_UP[p.elem] && p.addr == LAST_ADDR) ||
             (!ELEM_UP[p.elem] && p.addr == '0)) begin
            n.elem = (p.elem == E5) ? E0 : elem_t'(p.elem + 3'd1);
            n.addr = ELEM_UP[n.elem] ? '0 : LAST_ADDR;
         end else if (ELEM_UP[p.elem]) begin
            n.addr = p.addr + 1'b1;
         end else begin
            n.addr = p.addr - 1'b1;
         end
      end
      return n;
   endfunction

   function automatic logic is_last(pos_t p);
      return (p.elem == E5) && (p.addr == LAST_ADDR);
   endfunction

   // Write ops carry the element's write background, reads its read background.
   function automatic logic [DATA_WIDTH-1:0] op_data(pos_t p);
      logic bg;
      bg = elem_is_write(p.elem, p.ph) ? ELEM_WR_BG[p.elem] : ELEM_RD_BG[p.elem];
      return {DATA_WIDTH{bg}};
   endfunction

   state_t                state_q, state_d;
   pos_t                  pos_q, pos_d, pos_n1, pos_n2;
   logic                  drain_q, drain_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] wd_q, wd_d;
   logic                  pass_q, pass_d;
   logic                  clr;
   logic                  iss_valid;

   // Next-state and registered-output computation. pos_q is the operation
   // currently on the bus; wdata looks two positions ahead of it because
   // fault_mem samples wdata a cycle before the write.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      drain_d = drain_q;
      wr_d    = 1'b0;
      adr_d   = '0;
      wd_d    = '0;
      pass_d  = pass_q;
      clr     = 1'b0;
      pos_n1  = next_pos(pos_q);
      pos_n2  = next_pos(pos_n1);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               clr     = 1'b1;
               pass_d  = 1'b0;
               pos_d   = POS_FIRST;
               wr_d    = elem_is_write(POS_FIRST.elem, POS_FIRST.ph);
               adr_d   = POS_FIRST.addr;
               wd_d    = op_data(next_pos(POS_FIRST));
            end
         end
         ST_RUN: begin
            if (is_last(pos_q)) begin
               state_d = ST_DRAIN;
               drain_d = 1'b0;
            end else begin
               pos_d = pos_n1;
               wr_d  = elem_is_write(pos_n1.elem, pos_n1.ph);
               adr_d = pos_n1.addr;
               wd_d  = is_last(pos_n1) ? '0 : op_data(pos_n2);
            end
         end
         ST_DRAIN: begin
            if (drain_q) begin
               state_d = ST_DONE;
            end else begin
               drain_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            pass_d  = ~fail;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and sequencer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pos_q   <= POS_FIRST;
         drain_q <= 1'b0;
         wr_q    <= 1'b0;
         adr_q   <= '0;
         wd_q    <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         drain_q <= drain_d;
         wr_q    <= wr_d;
         adr_q   <= adr_d;
         wd_q    <= wd_d;
         pass_q  <= pass_d;
      end
   end

   assign iss_valid = (state_q == ST_RUN) && !wr_q;

   mbist_cmp_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .iss_valid (iss_valid),
      .iss_exp   (op_data(pos_q)),
      .iss_addr  (adr_q),
      .iss_elem  (pos_q.elem),
      .rdata     (rdata),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .fail_cnt  (fail_cnt)
   );

   assign write_read = wr_q;
   assign address    = adr_q;
   assign wdata      = wd_q;
   assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done       = (state_q == ST_DONE);
   // The final compare lands on the same edge that enters DONE, so pass is
   // taken from the live fail flag during DONE and held in pass_q afterwards.
   assign pass       = pass_q | (done & ~fail);

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with behavioural fault_mem models:
// instance A (8-bit counter, selectable stuck-at fault) and instance B
// (2-bit counter, every read returns the complement of the stored word).
module tb_mbist_march_ctrl;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int CAP = 15;
   localparam int N   = 10 * (CAP + 1);

   logic clk = 1'b0;
   logic rst;
   logic start;
   always #5 clk = ~clk;

   logic          a_wr, a_busy, a_done, a_pass, a_fail;
   logic [AW-1:0] a_addr, a_faddr;
   logic [DW-1:0] a_wdata, a_rdata;
   logic [2:0]    a_felem;
   logic [7:0]    a_fcnt;

   logic          b_wr, b_busy, b_done, b_pass, b_fail;
   logic [AW-1:0] b_addr, b_faddr;
   logic [DW-1:0] b_wdata, b_rdata;
   logic [2:0]    b_felem;
   logic [1:0]    b_fcnt;

   mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst), .start(start), .write_read(a_wr), .address(a_addr),
      .wdata(a_wdata), .rdata(a_rdata), .busy(a_busy), .done(a_done), .pass(a_pass),
      .fail(a_fail), .fail_addr(a_faddr), .fail_elem(a_felem), .fail_cnt(a_fcnt));

   mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .start(start), .write_read(b_wr), .address(b_addr),
      .wdata(b_wdata), .rdata(b_rdata), .busy(b_busy), .done(b_done), .pass(b_pass),
      .fail(b_fail), .fail_addr(b_faddr), .fail_elem(b_felem), .fail_cnt(b_fcnt));

   // fault_mem models: wdata registered then written; read data two cycles late.
   int            fault_mode;
   logic [DW-1:0] a_mem [0:CAP];
   logic [DW-1:0] a_wd_r;
   logic [AW-1:0] a_rad_r;
   logic [DW-1:0] b_mem [0:CAP];
   logic [DW-1:0] b_wd_r;
   logic [AW-1:0] b_rad_r;

   always @(posedge clk) begin
      a_wd_r  <= a_wdata;
      if (a_wr) a_mem[a_addr] <= a_wd_r;
      a_rad_r <= a_addr;
      if (fault_mode == 1 && a_rad_r == 4'd5) a_rdata <= a_mem[a_rad_r] & 8'hFE;
      else                                    a_rdata <= a_mem[a_rad_r];
   end

   always @(posedge clk) begin
      b_wd_r  <= b_wdata;
      if (b_wr) b_mem[b_addr] <= b_wd_r;
      b_rad_r <= b_addr;
      b_rdata <= ~b_mem[b_rad_r];
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected March C- operation list, written out element by element.
   logic          exp_wr  [N];
   logic [AW-1:0] exp_ad  [N];
   logic [DW-1:0] exp_dat [N];
   int            n_ops;

   task automatic push(input logic wr, input int a, input logic [DW-1:0] d);
      exp_wr[n_ops]  = wr;
      exp_ad[n_ops]  = AW'(a);
      exp_dat[n_ops] = d;
      n_ops++;
   endtask

   task automatic build_ops();
      n_ops = 0;
      for (int a = 0; a <= CAP; a++) push(1'b1, a, 8'h00);
      for (int a = 0; a <= CAP; a++) begin push(1'b0, a, 8'h00); push(1'b1, a, 8'hFF); end
      for (int a = 0; a <= CAP; a++) begin push(1'b0, a, 8'hFF); push(1'b1, a, 8'h00); end
      for (int a = CAP; a >= 0; a--) begin push(1'b0, a, 8'h00); push(1'b1, a, 8'hFF); end
      for (int a = CAP; a >= 0; a--) begin push(1'b0, a, 8'hFF); push(1'b1, a, 8'h00); end
      for (int a = 0; a <= CAP; a++) push(1'b0, a, 8'h00);
   endtask

   // One full run from edge S through the done cycle, checking every op.
   task automatic do_run(input bit hold, input logic exp_pass, input int exp_cnt,
                         input int exp_faddr, input int exp_felem, input bit chk_b);
      logic [DW-1:0] last_wd;
      @(negedge clk);
      start   = 1'b1;
      last_wd = a_wdata;
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (!hold) start = 1'b0;
            check("clr_fail", a_fail, 0);
            check("clr_cnt", a_fcnt, 0);
            check("clr_pass", a_pass, 0);
            check("run_busy", a_busy, 1);
         end
         if (!hold && k == 30) start = 1'b1;
         if (!hold && k == 31) start = 1'b0;
         check("op_wr", a_wr, exp_wr[k]);
         check("op_addr", a_addr, exp_ad[k]);
         if (exp_wr[k]) check("op_wdata", last_wd, exp_dat[k]);
         if (k == 79) check("e2_last_addr", a_addr, 15);
         if (k == 80) check("e3_first_addr", a_addr, 15);
         last_wd = a_wdata;
      end
      for (int d = 0; d < 2; d++) begin
         @(negedge clk);
         check("drain_busy", a_busy, 1);
         check("drain_done", a_done, 0);
      end
      @(negedge clk);
      check("done", a_done, 1);
      check("done_busy", a_busy, 0);
      check("pass", a_pass, exp_pass);
      check("fail", a_fail, !exp_pass);
      check("fail_cnt", a_fcnt, exp_cnt);
      check("fail_addr", a_faddr, exp_faddr);
      check("fail_elem", a_felem, exp_felem);
      if (chk_b) begin
         check("b_done", b_done, 1);
         check("b_pass", b_pass, 0);
         check("b_fail_cnt", b_fcnt, 3);
         check("b_fail_addr", b_faddr, 0);
         check("b_fail_elem", b_felem, 1);
      end
   endtask

   initial begin
      int seen_done;
      int seen_busy;
      build_ops();
      fault_mode = 0;
      start      = 1'b0;
      rst        = 1'b0;
      #1 rst     = 1'b1;
      #10;
      check("rst_wr", a_wr, 0);
      check("rst_addr", a_addr, 0);
      check("rst_wdata", a_wdata, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_pass", a_pass, 0);
      check("rst_fail", a_fail, 0);
      check("rst_fcnt", a_fcnt, 0);
      check("rst_faddr", a_faddr, 0);
      check("rst_felem", a_felem, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_wdata", a_wdata, 0);

      // Fault-free run, start pulse; B sees every read inverted.
      do_run(0, 1'b1, 0, 0, 0, 1);
      @(negedge clk);
      check("done_pulse", a_done, 0);
      check("pass_hold", a_pass, 1);

      // Stuck-at-0 on bit 0 of address 5.
      fault_mode = 1;
      do_run(0, 1'b0, 2, 5, 2, 0);
      repeat (3) @(negedge clk);
      check("fail_hold", a_fail, 1);
      check("fcnt_hold", a_fcnt, 2);

      // Reset mid-run at cycle S+50.
      fault_mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      check("pre_rst_busy", a_busy, 1);
      rst = 1'b1;
      #1;
      check("mrst_busy", a_busy, 0);
      check("mrst_wr", a_wr, 0);
      check("mrst_addr", a_addr, 0);
      check("mrst_wdata", a_wdata, 0);
      check("mrst_fail", a_fail, 0);
      check("mrst_fcnt", a_fcnt, 0);
      check("mrst_pass", a_pass, 0);
      @(negedge clk);
      @(negedge clk);
      rst       = 1'b0;
      seen_done = 0;
      seen_busy = 0;
      repeat (200) begin
         @(negedge clk);
         if (a_done) seen_done++;
         if (a_busy) seen_busy++;
      end
      check("rst_no_done", seen_done, 0);
      check("rst_no_busy", seen_busy, 0);
      do_run(0, 1'b1, 0, 0, 0, 0);

      // Back-to-back runs with start held high; flags clear at the new start.
      fault_mode = 1;
      do_run(1, 1'b0, 2, 5, 2, 0);
      fault_mode = 0;
      do_run(0, 1'b1, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
